// File: rtl/clock_pkg.sv
// Shared widths, field limits and mode encoding for the time-of-day counter.
package clock_pkg;

  localparam int unsigned HOUR_W   = 6;
  localparam int unsigned MIN_W    = 7;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_SEC  = 59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

endpackage

// File: rtl/key_debouncer.sv
// Raw active-low key -> 2-flop synchronizer -> debounced level -> one-cycle press pulse.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the clk domain; released (1) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Level follows the synced key after it has differed for DEBOUNCE_CYCLES cycles; pulse on fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// Hours/minutes/seconds counter with 1 Hz prescaler, two-key set mode and blink generator.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC   = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned BLINK_TICKS     = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_mode_n,
  input  logic              key_inc_n,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [1:0]        mode,
  output logic              blink
);

  localparam int unsigned PRE_W = $clog2(TICKS_PER_SEC);
  localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  mode_t            state;
  mode_t            state_next;
  logic             mode_press;
  logic             inc_press;
  logic [PRE_W-1:0] prescale;
  logic [BLK_W-1:0] blink_cnt;
  logic             run_en;
  logic             tick;
  logic             restart;
  logic             inc_hour;
  logic             inc_min;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_inc_n),
    .press (inc_press)
  );

  assign mode = state;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // MODE press steps RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    state_next = state;
    if (mode_press) begin
      case (state)
        RUN:      state_next = SET_HOUR;
        SET_HOUR: state_next = SET_MIN;
        default:  state_next = RUN;
      endcase
    end
  end

  // Per-state controls; a MODE press wins over INC and over a coincident tick.
  always_comb begin
    run_en   = 1'b0;
    tick     = 1'b0;
    restart  = 1'b0;
    inc_hour = 1'b0;
    inc_min  = 1'b0;
    case (state)
      RUN: begin
        run_en = ~mode_press;
        tick   = ~mode_press && (prescale == PRE_LAST);
      end
      SET_HOUR: inc_hour = inc_press && ~mode_press;
      SET_MIN: begin
        inc_min = inc_press && ~mode_press;
        restart = mode_press;
      end
      default: ;
    endcase
  end

  // Prescaler: free-runs in RUN, held in SET, cleared on return to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prescale <= '0;
    else if (restart) prescale <= '0;
    else if (run_en) prescale <= (prescale == PRE_LAST) ? '0 : prescale + PRE_W'(1);
  end

  // Time fields: ripple carry on tick, single-field increment while setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (tick) begin
      if (seconds == SEC_W'(MAX_SEC)) begin
        seconds <= '0;
        if (minutes == MIN_W'(MAX_MIN)) begin
          minutes <= '0;
          hours   <= (hours == HOUR_W'(MAX_HOUR)) ? '0 : hours + HOUR_W'(1);
        end else begin
          minutes <= minutes + MIN_W'(1);
        end
      end else begin
        seconds <= seconds + SEC_W'(1);
      end
    end else if (restart) begin
      seconds <= '0;
    end else if (inc_hour) begin
      hours <= (hours == HOUR_W'(MAX_HOUR)) ? '0 : hours + HOUR_W'(1);
    end else if (inc_min) begin
      minutes <= (minutes == MIN_W'(MAX_MIN)) ? '0 : minutes + MIN_W'(1);
    end
  end

  // Blink: forced high in RUN, restarts high on every mode change, toggles in SET states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (state_next == RUN || state_next != state) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper with a seconds-of-day reference model.
module tb_clock_timekeeper;

  localparam int TPS = 10;
  localparam int DEB = 4;
  localparam int BLK = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode_n;
  logic       key_inc_n;
  logic [5:0] hours;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds since midnight plus sub-second phase.
  int m_tod;
  int m_phase;
  int m_mode;
  int m_age;
  bit m_hist [2][16];
  bit m_lvl  [2];
  bit m_press[2];

  clock_timekeeper #(
    .TICKS_PER_SEC   (TPS),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_TICKS     (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .mode       (mode),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_tod   = 0;
    m_phase = 0;
    m_mode  = 0;
    m_age   = 0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) m_hist[k][j] = 1'b1;
      m_lvl[k]   = 1'b1;
      m_press[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit mp, ip, flip;
    int old_mode, h, m;
    mp = m_press[0];
    ip = m_press[1];
    old_mode = m_mode;
    case (m_mode)
      0: begin
        if (mp) m_mode = 1;
        else if (m_phase == TPS - 1) begin
          m_phase = 0;
          m_tod   = (m_tod + 1) % 86400;
        end else m_phase++;
      end
      1: begin
        if (mp) m_mode = 2;
        else if (ip) begin
          h = (m_tod / 3600 + 1) % 24;
          m_tod = h * 3600 + m_tod % 3600;
        end
      end
      default: begin
        if (mp) begin
          m_mode  = 0;
          m_tod   = m_tod - m_tod % 60;
          m_phase = 0;
        end else if (ip) begin
          m = ((m_tod / 60) % 60 + 1) % 60;
          m_tod = (m_tod / 3600) * 3600 + m * 60 + m_tod % 60;
        end
      end
    endcase
    if (m_mode == 0 || m_mode != old_mode) m_age = 0;
    else m_age++;
    // Debounced level flips once the key sampled 2..DEB+1 edges ago all disagree with it.
    for (int k = 0; k < 2; k++) begin
      for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = (k == 0) ? key_mode_n : key_inc_n;
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (m_hist[k][j] == m_lvl[k]) flip = 1'b0;
      m_press[k] = 1'b0;
      if (flip) begin
        m_lvl[k]   = ~m_lvl[k];
        m_press[k] = (m_lvl[k] == 1'b0);
      end
    end
  endtask

  task automatic compare();
    int exp_blink;
    exp_blink = (m_mode == 0) ? 1 : (((m_age / BLK) % 2 == 0) ? 1 : 0);
    check("hours",   int'(hours),   m_tod / 3600);
    check("minutes", int'(minutes), (m_tod / 60) % 60);
    check("seconds", int'(seconds), m_tod % 60);
    check("mode",    int'(mode),    m_mode);
    check("blink",   int'(blink),   exp_blink);
    check("in_range", int'(hours <= 6'd23 && minutes <= 7'd59 && seconds <= 6'd59), 1);
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic press(input bit do_mode, input bit do_inc);
    key_mode_n = ~do_mode;
    key_inc_n  = ~do_inc;
    repeat (8) cycle();
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (8) cycle();
  endtask

  initial begin
    int trans;
    logic [1:0] prev;
    model_reset();
    rst_n      = 1'b0;
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1'b1;
    check("rst_hours", int'(hours), 0);
    check("rst_minutes", int'(minutes), 0);
    check("rst_seconds", int'(seconds), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_blink", int'(blink), 1);

    // Key latency: MODE held 20 cycles gives exactly one transition, at edge 7.
    key_mode_n = 1'b0;
    trans = 0;
    prev  = mode;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (mode != prev) trans++;
      prev = mode;
      if (i == 6) check("lat_mode_e6", int'(mode), 0);
      if (i == 7) check("lat_mode_e7", int'(mode), 1);
    end
    check("lat_transitions", trans, 1);
    key_mode_n = 1'b1;
    repeat (10) cycle();

    // Bounce rejection in SET_HOUR, then one clean long press.
    repeat (3) begin
      key_inc_n = 1'b0;
      repeat (3) cycle();
      key_inc_n = 1'b1;
      repeat (3) cycle();
    end
    repeat (6) cycle();
    check("bounce_hours", int'(hours), 0);
    key_inc_n = 1'b0;
    repeat (10) cycle();
    key_inc_n = 1'b1;
    repeat (8) cycle();
    check("hold_hours", int'(hours), 1);

    // Simultaneous keys: MODE taken, INC dropped.
    press(1'b1, 1'b1);
    check("simul_mode", int'(mode), 2);
    check("simul_hours", int'(hours), 1);

    // Minutes wrap in SET_MIN.
    repeat (59) press(1'b0, 1'b1);
    check("min_59", int'(minutes), 59);
    press(1'b0, 1'b1);
    check("min_wrap", int'(minutes), 0);
    check("min_wrap_hours", int'(hours), 1);
    repeat (59) press(1'b0, 1'b1);

    // Back to RUN: seconds restart at 0, first tick 10 cycles later.
    key_mode_n = 1'b0;
    repeat (7) cycle();
    check("run_mode", int'(mode), 0);
    check("run_sec0", int'(seconds), 0);
    key_mode_n = 1'b1;
    repeat (9) cycle();
    check("tick_not_yet", int'(seconds), 0);
    cycle();
    check("first_tick", int'(seconds), 1);

    // Hours wrap in SET_HOUR, then load 23.
    press(1'b1, 1'b0);
    repeat (22) press(1'b0, 1'b1);
    check("hour_23", int'(hours), 23);
    press(1'b0, 1'b1);
    check("hour_wrap", int'(hours), 0);
    check("hour_wrap_min", int'(minutes), 59);
    repeat (23) press(1'b0, 1'b1);

    // Rollover from 23:59 through midnight.
    press(1'b1, 1'b0);
    key_mode_n = 1'b0;
    repeat (7) cycle();
    check("ro_start_sec", int'(seconds), 0);
    key_mode_n = 1'b1;
    repeat (583) cycle();
    check("ro_sec58", int'(seconds), 58);
    for (int i = 584; i <= 603; i++) begin
      cycle();
      if (i == 590) check("ro_2359_59", int'(hours) * 10000 + int'(minutes) * 100 + int'(seconds), 235959);
      if (i == 599) check("ro_pre_wrap", int'(seconds), 59);
      if (i == 600) check("ro_midnight", int'(hours) * 10000 + int'(minutes) * 100 + int'(seconds), 0);
    end

    // MODE lands on the same edge as a prescaler wrap: tick discarded.
    press(1'b1, 1'b0);
    check("freeze_mode", int'(mode), 1);
    check("freeze_sec", int'(seconds), 0);

    // Load 12:34 and run to 12:34:56.
    repeat (12) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (34) press(1'b0, 1'b1);
    key_mode_n = 1'b0;
    repeat (7) cycle();
    key_mode_n = 1'b1;
    repeat (560) cycle();
    check("at_123456", int'(hours) * 10000 + int'(minutes) * 100 + int'(seconds), 123456);

    // Async reset with MODE half-debounced.
    key_mode_n = 1'b0;
    repeat (4) cycle();
    #1 rst_n = 1'b0;
    #1;
    check("arst_hours", int'(hours), 0);
    check("arst_minutes", int'(minutes), 0);
    check("arst_seconds", int'(seconds), 0);
    check("arst_mode", int'(mode), 0);
    check("arst_blink", int'(blink), 1);
    key_mode_n = 1'b1;
    cycle();
    rst_n = 1'b1;
    repeat (15) cycle();
    check("arst_no_press", int'(mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
